regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Writer side of the register bank: collects results from the ALU and the
//  load/store unit, arbitrates them onto the single bank write port
//  (we/ain/din), and keeps a per-register busy scoreboard so decode stalls on
//  RAW/WAW hazards. Sits between execute/memory and the register bank.
// PARAMETERS
//  FIFO_DEPTH  4  entries in the memory-result FIFO (power of two, >=2)
// PORTS
//  clock        in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high
//  issue_valid  in   1   decode issues an instruction writing issue_rd
//  issue_rd     in   5   destination of issued instruction
//  query_rs1    in   5   decode source 1 being checked
//  query_rs2    in   5   decode source 2 being checked
//  hazard       out  1   comb: rs1, rs2 or issue_rd (if issue_valid) busy
//  alu_valid    in   1   ALU result present (no backpressure, one cycle)
//  alu_rd       in   5   ALU destination
//  alu_data     in   32  ALU result
//  mem_valid    in   1   load result offered
//  mem_ready    out  1   load result accepted (= FIFO not full)
//  mem_rd       in   5   load destination
//  mem_data     in   32  load data
//  wb_we        out  1   to bank we (registered)
//  wb_addr      out  5   to bank ain (registered)
//  wb_data      out  32  to bank din (registered)
//  pending      out  1   any busy bit set
// BEHAVIOUR
//  - Reset: busy[31:0]=0, FIFO empty, wb_we=0, wb_addr=0, wb_data=0; takes
//    effect immediately, mid-operation included; in-flight results dropped.
//  - r0: never marked busy, never written; results with rd=0 are consumed
//    (ALU discarded, mem popped) with wb_we=0. hazard ignores r0 queries.
//  - Issue: issue_valid & !hazard & issue_rd!=0 sets busy[issue_rd] at edge.
//    issue_valid while hazard=1 is ignored (no state change); one pending
//    writer per register is therefore guaranteed.
//  - mem handshake: push when mem_valid & mem_ready. mem_ready=0 when FIFO
//    holds FIFO_DEPTH entries. No same-cycle bypass: an empty FIFO pushed in
//    cycle N pops no earlier than cycle N+1. Push and pop in one cycle allowed.
//  - Arbitration each cycle: alu_valid wins; else FIFO head pops if non-empty.
//    Selected result registered at the edge -> wb_* valid the next cycle
//    (ALU latency 1 cycle, mem latency >=2 cycles).
//  - Busy clear: busy[wb_addr] cleared at the edge where wb_we=1 is sampled,
//    i.e. the same edge the bank writes; bank value is current from then on.
//  - Clear and set never hit the same register in one cycle (issue blocked
//    while busy); clear and set of different registers both take effect.
//  - Results to non-busy rd are still written (no checking); bench flags it.
// CONFIGURATION
//  FWD_EN defined: adds outputs fwd1_hit, fwd2_hit (1) and fwd_data (32).
//    fwdN_hit=wb_we & wb_addr==query_rsN & query_rsN!=0; fwd_data=wb_data.
//    hazard ignores a source with fwdN_hit, saving one stall cycle.
//    issue_rd WAW check unchanged.
//  FWD_EN undefined: ports absent; hazard stays asserted through the
//    wb_we cycle and drops the cycle after.
// TESTING
//  1 issue rd=5; cycle N alu_valid rd=5 data=0xDEADBEEF -> N+1 wb_we=1,
//    wb_addr=5, wb_data=0xDEADBEEF; busy[5] clear from N+2; pending 1->0.
//  2 query_rs1=5 while busy[5] -> hazard=1 until N+2 (no FWD_EN) / until N+1
//    with fwd1_hit=1, fwd_data=0xDEADBEEF (FWD_EN).
//  3 FIFO_DEPTH=4, alu_valid held high, 5 mem pushes -> mem_ready=0 after 4th;
//    drop alu_valid -> 4 mem writebacks in push order, one per cycle.
//  4 alu rd=0 and mem rd=0 -> wb_we stays 0; FIFO drains; no busy change.
//  5 issue rd=7 while busy[7] -> hazard=1, busy unchanged, later writeback
//    clears busy[7] and a re-issue succeeds.
//  6 reset asserted mid-stream with FIFO=3, busy!=0 -> same cycle: wb_we=0,
//    mem_ready=1, pending=0; no write after release.

Source files
------------

// File: rtl/regfile_writeback.sv
// Writeback arbiter and busy scoreboard; `define FWD_EN adds forwarding ports.
// Latency: ALU result 1 cycle to wb_*, load result >=2 cycles through the FIFO.
// Backpressure: ALU never stalls (wins arbitration); loads held off by mem_ready when FIFO full.

module rwb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  assign push_rdy = (count != (AW+1)'(DEPTH));
  assign pop_vld  = (count != '0);
  assign push     = push_vld & push_rdy;
  assign pop      = pop_vld & pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module regfile_writeback #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  query_rs1,
  input  logic [4:0]  query_rs2,
  output logic        hazard,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
`ifdef FWD_EN
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd_data,
`endif
  output logic        pending
);
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  logic [31:0] busy;
  logic [31:0] busy_nxt;
  wb_ent_t     mem_ent;
  wb_ent_t     fifo_head;
  wb_ent_t     sel_ent;
  logic        fifo_vld;
  logic        sel_vld;
  logic        issue_set;
  logic        byp1;
  logic        byp2;

  assign mem_ent = '{rd: mem_rd, data: mem_data};

  rwb_fifo #(.WIDTH($bits(wb_ent_t)), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (mem_valid),
    .push_rdy (mem_ready),
    .push_dat (mem_ent),
    .pop_vld  (fifo_vld),
    .pop_rdy  (!alu_valid),
    .pop_dat  (fifo_head)
  );

  assign sel_vld = alu_valid | fifo_vld;
  assign sel_ent = alu_valid ? wb_ent_t'{rd: alu_rd, data: alu_data} : fifo_head;

`ifdef FWD_EN
  assign byp1     = wb_we & (wb_addr == query_rs1) & (query_rs1 != 5'd0);
  assign byp2     = wb_we & (wb_addr == query_rs2) & (query_rs2 != 5'd0);
  assign fwd1_hit = byp1;
  assign fwd2_hit = byp2;
  assign fwd_data = wb_data;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // r0 is never busy, so source/destination zero can never stall decode.
  assign hazard = ((query_rs1 != 5'd0) & busy[query_rs1] & !byp1)
                | ((query_rs2 != 5'd0) & busy[query_rs2] & !byp2)
                | (issue_valid & (issue_rd != 5'd0) & busy[issue_rd]);

  assign issue_set = issue_valid & !hazard & (issue_rd != 5'd0);
  assign pending   = |busy;

  always_comb begin
    busy_nxt = busy;
    if (wb_we)     busy_nxt[wb_addr]  = 1'b0;
    if (issue_set) busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      busy <= busy_nxt;
      if (sel_vld) begin
        wb_we   <= (sel_ent.rd != 5'd0);
        wb_addr <= sel_ent.rd;
        wb_data <= sel_ent.data;
      end else begin
        wb_we   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback; FWD_EN selects the forwarding variant.
module tb_regfile_writeback;
  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        hazard;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pending;
`ifdef FWD_EN
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd_data;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  regfile_writeback #(.FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .query_rs1   (query_rs1),
    .query_rs2   (query_rs2),
    .hazard      (hazard),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
`ifdef FWD_EN
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit),
    .fwd_data    (fwd_data),
`endif
    .pending     (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Every bank write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && wb_we) begin
      if (exp_q.size() == 0) begin
        chk_eq("wb_extra", {59'd0, wb_addr}, 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk_eq("wb_addr", wb_addr, e.a);
        chk_eq("wb_data", wb_data, e.d);
      end
    end
  end

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_rd = 0; query_rs1 = 0; query_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    repeat (2) @(negedge clock);
    chk_eq("rst_we", wb_we, 0);
    chk_eq("rst_addr", wb_addr, 0);
    chk_eq("rst_data", wb_data, 0);
    chk_eq("rst_rdy", mem_ready, 1);
    chk_eq("rst_pend", pending, 0);
    chk_eq("rst_haz", hazard, 0);
    cyc(); reset = 1'b0;

    // ALU writeback, latency and RAW stall on rs1
    issue_valid = 1; issue_rd = 5;
    @(negedge clock); chk_eq("t1_issue_haz", hazard, 0);
    cyc(); issue_valid = 0; query_rs1 = 5;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; push_exp(5, 32'hDEADBEEF);
    @(negedge clock);
    chk_eq("t1_haz_n", hazard, 1);
    chk_eq("t1_pend_n", pending, 1);
    chk_eq("t1_we_n", wb_we, 0);
    cyc(); alu_valid = 0;
    @(negedge clock);
    chk_eq("t1_we_n1", wb_we, 1);
    chk_eq("t1_addr_n1", wb_addr, 5);
    chk_eq("t1_data_n1", wb_data, 32'hDEADBEEF);
    chk_eq("t1_pend_n1", pending, 1);
`ifdef FWD_EN
    chk_eq("t2_haz_n1", hazard, 0);
    chk_eq("t2_fwd1", fwd1_hit, 1);
    chk_eq("t2_fwd2", fwd2_hit, 0);
    chk_eq("t2_fwd_data", fwd_data, 32'hDEADBEEF);
`else
    chk_eq("t2_haz_n1", hazard, 1);
`endif
    cyc();
    @(negedge clock);
    chk_eq("t1_haz_n2", hazard, 0);
    chk_eq("t1_pend_n2", pending, 0);
    chk_eq("t1_we_n2", wb_we, 0);

    // WAW on issue, ignored issue under hazard, re-issue after clear
    cyc(); query_rs1 = 0; issue_valid = 1; issue_rd = 7;
    @(negedge clock); chk_eq("t5_first", hazard, 0);
    cyc(); issue_rd = 7;
    @(negedge clock); chk_eq("t5_waw", hazard, 1);
    cyc(); issue_rd = 9; query_rs2 = 7;
    @(negedge clock); chk_eq("t5_rs2", hazard, 1);
    cyc(); issue_valid = 0; query_rs2 = 9;
    @(negedge clock);
    chk_eq("t5_ignored", hazard, 0);
    chk_eq("t5_pend", pending, 1);
    cyc(); query_rs2 = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h77; push_exp(7, 32'h77);
    cyc(); alu_valid = 0;
    cyc(); issue_valid = 1; issue_rd = 7;
    @(negedge clock); chk_eq("t5_reissue", hazard, 0);
    cyc(); issue_valid = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h770; push_exp(7, 32'h770);
    @(negedge clock); chk_eq("t5_pend2", pending, 1);
    cyc(); alu_valid = 0;
    cyc();
    @(negedge clock); chk_eq("t5_pend3", pending, 0);

    // FIFO fill behind a busy ALU, then ordered drain
    for (int i = 0; i < 4; i++) begin
      cyc(); issue_valid = 1; issue_rd = 5'(10 + i);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      issue_valid = 0; alu_valid = 1; alu_rd = 0;
      mem_valid = 1; mem_rd = 5'(10 + i); mem_data = 32'hA000 + i;
      @(negedge clock);
      chk_eq("t3_rdy", mem_ready, (i < 4) ? 1 : 0);
      if (i < 4) push_exp(5'(10 + i), 32'hA000 + i);
    end
    cyc(); mem_valid = 0; alu_valid = 0;
    @(negedge clock); chk_eq("t3_we_pre", wb_we, 0);
    for (int j = 0; j < 4; j++) begin
      cyc();
      @(negedge clock); chk_eq("t3_drain_we", wb_we, 1);
    end
    cyc();
    @(negedge clock);
    chk_eq("t3_we_post", wb_we, 0);
    chk_eq("t3_pend", pending, 0);
    chk_eq("t3_rdy_post", mem_ready, 1);

    // r0 results consumed silently; load latency without bypass
    cyc(); alu_valid = 1; alu_rd = 0; alu_data = 32'h1;
    cyc(); alu_valid = 0; mem_valid = 1; mem_rd = 0; mem_data = 32'h2;
    @(negedge clock); chk_eq("t4_alu0", wb_we, 0);
    cyc(); mem_valid = 0;
    @(negedge clock); chk_eq("t4_mem0a", wb_we, 0);
    cyc();
    @(negedge clock);
    chk_eq("t4_mem0b", wb_we, 0);
    chk_eq("t4_rdy", mem_ready, 1);
    chk_eq("t4_pend", pending, 0);
    cyc(); issue_valid = 1; issue_rd = 3;
    cyc(); issue_valid = 0; mem_valid = 1; mem_rd = 3; mem_data = 32'h333; push_exp(3, 32'h333);
    @(negedge clock); chk_eq("t4_lat0", wb_we, 0);
    cyc(); mem_valid = 0;
    @(negedge clock); chk_eq("t4_lat1", wb_we, 0);
    cyc();
    @(negedge clock); chk_eq("t4_lat2", wb_we, 1);
    cyc();
    @(negedge clock); chk_eq("t4_pend2", pending, 0);

    // Reset mid-stream: FIFO holds 3, busy set, write on the bank port
    cyc(); issue_valid = 1; issue_rd = 20;
    cyc(); issue_rd = 21; alu_valid = 1; alu_rd = 0;
    mem_valid = 1; mem_rd = 0; mem_data = 32'h1;
    cyc(); issue_valid = 0; mem_data = 32'h2;
    cyc(); mem_data = 32'h3;
    cyc(); mem_valid = 0; alu_rd = 20; alu_data = 32'h2020; push_exp(20, 32'h2020);
    cyc(); alu_rd = 0;
    chk_eq("t6_pre_we", wb_we, 1);
    reset = 1'b1;
    #1;
    chk_eq("t6_we", wb_we, 0);
    chk_eq("t6_rdy", mem_ready, 1);
    chk_eq("t6_pend", pending, 0);
    chk_eq("t6_addr", wb_addr, 0);
    exp_q.delete();
    cyc(); reset = 1'b0; alu_valid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk_eq("t6_post_we", wb_we, 0);
      chk_eq("t6_post_pend", pending, 0);
      cyc();
    end

    chk_eq("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
